// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: op codes, bus widths and the issue-queue entry layout.
// The widths below are the ones the issue queue is built for.
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 6;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADDI = 4'd2,
        OP_LUI  = 4'd3,
        OP_ORI  = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRAI = 4'd6,
        OP_LB   = 4'd7,
        OP_LW   = 4'd8,
        OP_SB   = 4'd9,
        OP_SW   = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [OP_W-1:0]   optype;
        logic [PREG_W-1:0] src1_tag;
        logic              src1_rdy;
        logic [XLEN-1:0]   src1_val;
        logic [PREG_W-1:0] src2_tag;
        logic              src2_rdy;
        logic [XLEN-1:0]   src2_val;
        logic [XLEN-1:0]   imm;
        logic [PREG_W-1:0] dr;
    } iq_entry_t;

    function automatic logic is_nop(input logic [OP_W-1:0] op);
        return op == OP_NOP;
    endfunction

endpackage

// File: rtl/iq_oldest_ready_pick.sv
// Fixed-priority pick: reports whether any request is set and the lowest set index.
// Used both for the oldest ready queue entry and for the lowest free ALU.
module iq_oldest_ready_pick #(
    parameter int N = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top so the lowest set index is the last writer.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing issue queue for the integer ALUs: buffers renamed ops, wakes operands from
// the result broadcast and issues the oldest ready op to the lowest free ALU each cycle.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_ALU = 3,
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int PREG_W  = alu_pkg::PREG_W,
    parameter int OP_W    = alu_pkg::OP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [OP_W-1:0]           enq_optype,
    input  logic [PREG_W-1:0]         enq_src1_tag,
    input  logic                      enq_src1_rdy,
    input  logic [XLEN-1:0]           enq_src1_val,
    input  logic [PREG_W-1:0]         enq_src2_tag,
    input  logic                      enq_src2_rdy,
    input  logic [XLEN-1:0]           enq_src2_val,
    input  logic [XLEN-1:0]           enq_imm,
    input  logic [PREG_W-1:0]         enq_dr,
    input  logic [NUM_ALU-1:0]        alu_free,
    input  logic [NUM_ALU-1:0]        cdb_valid,
    input  logic [NUM_ALU*PREG_W-1:0] cdb_tag,
    input  logic [NUM_ALU*XLEN-1:0]   cdb_data,
    output logic [NUM_ALU-1:0]        alu_number,
    output logic [OP_W-1:0]           optype,
    output logic [XLEN-1:0]           data_in_sr1,
    output logic [XLEN-1:0]           data_in_sr2,
    output logic [XLEN-1:0]           data_in_imm,
    output logic [PREG_W-1:0]         dr_in,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

    // Slots [0, count_q) are live; slot 0 is the oldest.
    iq_entry_t          ent_q [DEPTH];
    iq_entry_t          ent_d [DEPTH];
    iq_entry_t          woke  [DEPTH];
    iq_entry_t          enq_e;
    logic [CW-1:0]      count_q, count_d, wr_idx;

    logic [NUM_ALU-1:0] alu_num_q, alu_num_d;
    logic [OP_W-1:0]    optype_q, optype_d;
    logic [XLEN-1:0]    sr1_q, sr1_d;
    logic [XLEN-1:0]    sr2_q, sr2_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic [PREG_W-1:0]  dr_q, dr_d;

    logic [DEPTH-1:0]   ent_rdy;
    logic               ent_found, alu_found;
    logic [AW-1:0]      ent_idx;
    logic [LW-1:0]      alu_idx;
    logic               do_issue, do_enq;

    // Returns {rdy, val} after looking the tag up on the broadcast; lowest lane wins.
    function automatic logic [XLEN:0] wake(input logic rdy, input logic [PREG_W-1:0] tag,
                                           input logic [XLEN-1:0] val);
        logic [XLEN:0] r;
        r = {rdy, val};
        if (!rdy) begin
            for (int i = NUM_ALU - 1; i >= 0; i--) begin
                if (cdb_valid[i] && cdb_tag[i*PREG_W +: PREG_W] == tag)
                    r = {1'b1, cdb_data[i*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            ent_rdy[k] = (CW'(k) < count_q) && ent_q[k].src1_rdy && ent_q[k].src2_rdy;
    end

    iq_oldest_ready_pick #(.N(DEPTH)) u_pick_ent (
        .req_i   (ent_rdy),
        .found_o (ent_found),
        .idx_o   (ent_idx)
    );

    iq_oldest_ready_pick #(.N(NUM_ALU)) u_pick_alu (
        .req_i   (alu_free),
        .found_o (alu_found),
        .idx_o   (alu_idx)
    );

    // Select looks only at registered state, so a wakeup never issues on its own edge.
    assign enq_ready = (count_q < CW'(DEPTH)) && !flush;
    assign do_issue  = ent_found && alu_found && !flush;
    assign do_enq    = enq_valid && enq_ready && !is_nop(enq_optype);
    assign wr_idx    = count_q - CW'(do_issue);

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            woke[k] = ent_q[k];
            {woke[k].src1_rdy, woke[k].src1_val} =
                wake(ent_q[k].src1_rdy, ent_q[k].src1_tag, ent_q[k].src1_val);
            {woke[k].src2_rdy, woke[k].src2_val} =
                wake(ent_q[k].src2_rdy, ent_q[k].src2_tag, ent_q[k].src2_val);
        end

        enq_e.optype   = enq_optype;
        enq_e.src1_tag = enq_src1_tag;
        enq_e.src2_tag = enq_src2_tag;
        enq_e.imm      = enq_imm;
        enq_e.dr       = enq_dr;
        {enq_e.src1_rdy, enq_e.src1_val} = wake(enq_src1_rdy, enq_src1_tag, enq_src1_val);
        {enq_e.src2_rdy, enq_e.src2_val} = wake(enq_src2_rdy, enq_src2_tag, enq_src2_val);
    end

    // Collapse over the issued slot, then drop the new op into the first free slot.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            if (do_issue && AW'(k) >= ent_idx && k < DEPTH - 1)
                ent_d[k] = woke[(k + 1) % DEPTH];
            else
                ent_d[k] = woke[k];
            if (do_enq && CW'(k) == wr_idx)
                ent_d[k] = enq_e;
        end

        if (flush)
            count_d = '0;
        else
            count_d = count_q - CW'(do_issue) + CW'(do_enq);
    end

    always_comb begin
        alu_num_d = '0;
        optype_d  = optype_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        imm_d     = imm_q;
        dr_d      = dr_q;
        if (do_issue) begin
            alu_num_d = NUM_ALU'(1) << alu_idx;
            optype_d  = ent_q[ent_idx].optype;
            sr1_d     = ent_q[ent_idx].src1_val;
            sr2_d     = ent_q[ent_idx].src2_val;
            imm_d     = ent_q[ent_idx].imm;
            dr_d      = ent_q[ent_idx].dr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            alu_num_q <= '0;
            optype_q  <= '0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            imm_q     <= '0;
            dr_q      <= '0;
        end else begin
            count_q   <= count_d;
            alu_num_q <= alu_num_d;
            optype_q  <= optype_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            imm_q     <= imm_d;
            dr_q      <= dr_d;
        end
    end

    // Slot contents need no reset: liveness comes from count_q alone.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++)
            ent_q[k] <= ent_d[k];
    end

    assign alu_number  = alu_num_q;
    assign optype      = optype_q;
    assign data_in_sr1 = sr1_q;
    assign data_in_sr2 = sr2_q;
    assign data_in_imm = imm_q;
    assign dr_in       = dr_q;
    assign count       = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a queue-level model predicts every issue and the
// occupancy; a monitor compares on each falling edge.
module tb_alu_issue_queue;

    localparam int DEPTH = 8;
    localparam int NA    = 3;
    localparam int XL    = 32;
    localparam int PW    = 6;
    localparam int OW    = 4;

    logic              clk = 1'b0;
    logic              rst, flush, enq_valid, enq_ready;
    logic [OW-1:0]     enq_optype, optype;
    logic [PW-1:0]     enq_src1_tag, enq_src2_tag, enq_dr, dr_in;
    logic              enq_src1_rdy, enq_src2_rdy;
    logic [XL-1:0]     enq_src1_val, enq_src2_val, enq_imm;
    logic [NA-1:0]     alu_free, cdb_valid, alu_number;
    logic [NA*PW-1:0]  cdb_tag;
    logic [NA*XL-1:0]  cdb_data;
    logic [XL-1:0]     data_in_sr1, data_in_sr2, data_in_imm;
    logic [3:0]        count;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .NUM_ALU(NA), .XLEN(XL), .PREG_W(PW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_optype(enq_optype),
        .enq_src1_tag(enq_src1_tag), .enq_src1_rdy(enq_src1_rdy), .enq_src1_val(enq_src1_val),
        .enq_src2_tag(enq_src2_tag), .enq_src2_rdy(enq_src2_rdy), .enq_src2_val(enq_src2_val),
        .enq_imm(enq_imm), .enq_dr(enq_dr),
        .alu_free(alu_free), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_number(alu_number), .optype(optype), .data_in_sr1(data_in_sr1),
        .data_in_sr2(data_in_sr2), .data_in_imm(data_in_imm), .dr_in(dr_in), .count(count)
    );

    typedef struct {
        logic [OW-1:0] op;
        logic [PW-1:0] t1, t2, dr;
        logic          r1, r2;
        logic [XL-1:0] v1, v2, imm;
    } m_ent_t;

    typedef struct {
        int            cyc;
        logic [NA-1:0] num;
        logic [OW-1:0] op;
        logic [XL-1:0] s1, s2, imm;
        logic [PW-1:0] dr;
    } exp_t;

    m_ent_t mq[$];
    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     cycn = 0;
    bit     checking = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycn);
        end
    endfunction

    // Broadcast lookup on one operand, lanes scanned lowest first.
    function automatic void mwake(inout logic r, input logic [PW-1:0] t, inout logic [XL-1:0] v);
        if (r) return;
        for (int i = 0; i < NA; i++) begin
            if (cdb_valid[i] && cdb_tag[i*PW +: PW] == t) begin
                r = 1'b1;
                v = cdb_data[i*XL +: XL];
                return;
            end
        end
    endfunction

    // Reference model: age-ordered list of ops, stepped once per rising edge.
    initial forever begin
        int sz, idx, a;
        m_ent_t n;
        exp_t e;
        @(posedge clk);
        cycn++;
        if (rst || flush) begin
            mq.delete();
        end else begin
            sz  = mq.size();
            idx = -1;
            a   = -1;
            for (int i = 0; i < mq.size(); i++)
                if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
            for (int i = 0; i < NA; i++)
                if (a < 0 && alu_free[i]) a = i;
            if (idx >= 0 && a >= 0) begin
                e.cyc = cycn;
                e.num = NA'(1) << a;
                e.op  = mq[idx].op;
                e.s1  = mq[idx].v1;
                e.s2  = mq[idx].v2;
                e.imm = mq[idx].imm;
                e.dr  = mq[idx].dr;
                sb.push_back(e);
                mq.delete(idx);
            end
            for (int i = 0; i < mq.size(); i++) begin
                n = mq[i];
                mwake(n.r1, n.t1, n.v1);
                mwake(n.r2, n.t2, n.v2);
                mq[i] = n;
            end
            if (enq_valid && sz < DEPTH && enq_optype != 0) begin
                n.op = enq_optype;  n.t1 = enq_src1_tag;  n.t2 = enq_src2_tag;
                n.r1 = enq_src1_rdy; n.v1 = enq_src1_val; n.r2 = enq_src2_rdy;
                n.v2 = enq_src2_val; n.imm = enq_imm;     n.dr = enq_dr;
                mwake(n.r1, n.t1, n.v1);
                mwake(n.r2, n.t2, n.v2);
                mq.push_back(n);
            end
        end
    end

    // Monitor: occupancy and accept every cycle, issue payload whenever alu_number is set.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (checking) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("enq_ready", 64'(enq_ready), 64'((mq.size() < DEPTH) && !flush));
            chk("onehot", 64'($onehot0(alu_number)), 64'(1));
            if (alu_number != '0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got alu_number=%b want none (cycle %0d)",
                             alu_number, cycn);
                end else begin
                    e = sb.pop_front();
                    chk("issue_cycle", 64'(cycn), 64'(e.cyc));
                    chk("alu_number", 64'(alu_number), 64'(e.num));
                    chk("optype", 64'(optype), 64'(e.op));
                    chk("sr1", 64'(data_in_sr1), 64'(e.s1));
                    chk("sr2", 64'(data_in_sr2), 64'(e.s2));
                    chk("imm", 64'(data_in_imm), 64'(e.imm));
                    chk("dr_in", 64'(dr_in), 64'(e.dr));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input int op, input int t1, input bit r1, input logic [XL-1:0] v1,
                       input int t2, input bit r2, input logic [XL-1:0] v2, input int dr);
        enq_valid    = 1'b1;
        enq_optype   = OW'(op);
        enq_src1_tag = PW'(t1);
        enq_src1_rdy = r1;
        enq_src1_val = v1;
        enq_src2_tag = PW'(t2);
        enq_src2_rdy = r2;
        enq_src2_val = v2;
        enq_imm      = v1 ^ 32'h0000_1000;
        enq_dr       = PW'(dr);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_alu_number"}, 64'(alu_number), 64'(0));
        chk({tag, "_outs"}, 64'(optype) | 64'(data_in_sr1) | 64'(data_in_sr2)
                            | 64'(data_in_imm) | 64'(dr_in), 64'(0));
        chk({tag, "_count"}, 64'(count), 64'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alu_free = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        enq(0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        enq_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        checking = 1'b1;
        chk_zero("reset");

        // Ready ADD: issue on the following edge for exactly one cycle.
        alu_free = 3'b111;
        enq(1, 0, 1'b1, 5, 0, 1'b1, 7, 12);
        step();
        enq_valid = 1'b0;
        step();
        chk("t1_alu_number", 64'(alu_number), 64'(3'b001));
        chk("t1_sr1", 64'(data_in_sr1), 64'(5));
        chk("t1_sr2", 64'(data_in_sr2), 64'(7));
        chk("t1_dr", 64'(dr_in), 64'(12));
        step();
        chk("t1_drop", 64'(alu_number), 64'(0));

        // Wakeup from lane 1, issue one edge after it.
        enq(1, 9, 1'b0, 0, 0, 1'b1, 3, 20);
        step();
        enq_valid = 1'b0;
        step();
        step();
        cdb_valid = 3'b010; cdb_tag[PW +: PW] = 6'd9; cdb_data[XL +: XL] = 32'h55;
        step();
        cdb_valid = '0;
        chk("t2_no_same_edge", 64'(alu_number), 64'(0));
        step();
        chk("t2_alu_number", 64'(alu_number), 64'(3'b001));
        chk("t2_sr1", 64'(data_in_sr1), 64'(32'h55));
        step();

        // Fill with no free ALU, push against full, then drain through ALU 2 in age order.
        alu_free = '0;
        for (int i = 0; i < DEPTH; i++) begin
            enq(5, 0, 1'b1, 100 + i, 0, 1'b1, i, i);
            step();
        end
        chk("t3_full_count", 64'(count), 64'(8));
        chk("t3_full_ready", 64'(enq_ready), 64'(0));
        enq(1, 0, 1'b1, 999, 0, 1'b1, 999, 33);
        step();
        chk("t3_refused", 64'(count), 64'(8));
        enq_valid = 1'b0;
        alu_free = 3'b100;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("t3_alu_number", 64'(alu_number), 64'(3'b100));
            chk("t3_age_order", 64'(data_in_sr1), 64'(100 + i));
        end
        chk("t3_drained", 64'(count), 64'(0));

        // Enqueue bypass from lane 0.
        alu_free = 3'b111;
        enq(5, 0, 1'b1, 1, 4, 1'b0, 0, 7);
        cdb_valid = 3'b001; cdb_tag[0 +: PW] = 6'd4; cdb_data[0 +: XL] = 32'hABCD;
        step();
        enq_valid = 1'b0; cdb_valid = '0;
        step();
        chk("t4_alu_number", 64'(alu_number), 64'(3'b001));
        chk("t4_bypass_sr2", 64'(data_in_sr2), 64'(32'hABCD));
        step();

        // Flush beats a pending issue and a concurrent enqueue.
        alu_free = '0;
        for (int i = 0; i < 5; i++) begin
            enq(2, 0, 1'b1, 50 + i, 0, 1'b1, 0, i);
            step();
        end
        alu_free = 3'b111; flush = 1'b1;
        enq(1, 0, 1'b1, 77, 0, 1'b1, 77, 1);
        step();
        flush = 1'b0; enq_valid = 1'b0;
        chk("t5_count", 64'(count), 64'(0));
        chk("t5_alu_number", 64'(alu_number), 64'(0));
        step();
        chk("t5_no_stale", 64'(alu_number), 64'(0));

        // Reset with an issue in flight and ready entries behind it.
        alu_free = '0;
        for (int i = 0; i < 3; i++) begin
            enq(1, 0, 1'b1, 60 + i, 0, 1'b1, 1, i);
            step();
        end
        enq_valid = 1'b0;
        alu_free = 3'b111;
        step();
        chk("t6_inflight", 64'(alu_number), 64'(3'b001));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("t6_rst");
        step();
        chk("t6_no_stale", 64'(alu_number), 64'(0));

        // Random traffic with small tag space so wakeups and duplicate lanes are common.
        for (int n = 0; n < 1500; n++) begin
            enq($urandom_range(0, 10), $urandom_range(0, 7), $urandom_range(0, 2) != 0,
                $urandom, $urandom_range(0, 7), $urandom_range(0, 2) != 0, $urandom,
                $urandom_range(0, 63));
            enq_valid = $urandom_range(0, 3) != 0;
            cdb_valid = NA'($urandom);
            for (int i = 0; i < NA; i++) begin
                cdb_tag[i*PW +: PW]  = PW'($urandom_range(0, 7));
                cdb_data[i*XL +: XL] = $urandom;
            end
            alu_free = NA'($urandom);
            flush    = $urandom_range(0, 79) == 0;
            rst      = $urandom_range(0, 199) == 0;
            step();
        end

        enq_valid = 1'b0; cdb_valid = '0; flush = 1'b0; rst = 1'b0; alu_free = '0;
        step();
        step();
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
